// File: rtl/uvma_spi_mstr_core.sv
// SPI master engine: all four CPOL/CPHA modes, runtime SCK divider,
// parametrised word width, multi-slave select and MSB/LSB bit order.
module uvma_spi_mstr_core #(
    parameter int SS_WIDTH   = 1,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  cfg_lsb_first,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [SS_WIDTH-1:0]   req_ss,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [SS_WIDTH-1:0]   ss
);

    localparam int EW = $clog2(2*DATA_WIDTH+1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_WIDTH-1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [EW-1:0]         ecnt;
    logic [DATA_WIDTH-1:0] tx;
    logic [DATA_WIDTH-1:0] rx;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  lsb_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic                  tick;
    logic                  leading;
    logic                  last;

    // Bit currently at the head of the shift order
    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v,
                                      input logic lsb);
        return lsb ? v[0] : v[DATA_WIDTH-1];
    endfunction

    // Move the next bit to the head of the shift order
    function automatic logic [DATA_WIDTH-1:0] advance(
        input logic [DATA_WIDTH-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DATA_WIDTH-1:1]}
                   : {v[DATA_WIDTH-2:0], 1'b0};
    endfunction

    // Insert a received bit so the word assembles in transmit order
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] v, input logic lsb, input logic b);
        return lsb ? {b, v[DATA_WIDTH-1:1]}
                   : {v[DATA_WIDTH-2:0], b};
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign tick      = (cnt == div_q);
    assign leading   = ~ecnt[0];
    assign last      = (ecnt == LAST_EDGE);

    // Transfer sequencer with registered SPI pins and response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ecnt      <= '0;
            tx        <= '0;
            rx        <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            div_q     <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            ss        <= '1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    sck  <= cfg_cpol;
                    mosi <= 1'b0;
                    if (req_valid) begin
                        cpol_q <= cfg_cpol;
                        cpha_q <= cfg_cpha;
                        lsb_q  <= cfg_lsb_first;
                        div_q  <= cfg_div;
                        tx     <= req_data;
                        rx     <= '0;
                        ss     <= ~req_ss;
                        cnt    <= '0;
                        state  <= SETUP;
                        mosi   <= cfg_cpha ? 1'b0
                                  : head_bit(req_data, cfg_lsb_first);
                    end
                end
                SETUP: begin
                    if (tick) begin
                        cnt   <= '0;
                        ecnt  <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                XFER: begin
                    if (tick) begin
                        cnt  <= '0;
                        sck  <= ~sck;
                        ecnt <= ecnt + EW'(1);
                        if (leading) begin
                            if (!cpha_q) begin
                                rx <= shift_in(rx, lsb_q, miso);
                            end else begin
                                mosi <= head_bit(tx, lsb_q);
                                tx   <= advance(tx, lsb_q);
                            end
                        end else begin
                            if (cpha_q) begin
                                rx <= shift_in(rx, lsb_q, miso);
                            end else if (!last) begin
                                tx   <= advance(tx, lsb_q);
                                mosi <= head_bit(advance(tx, lsb_q), lsb_q);
                            end
                            if (last) begin
                                state <= HOLD;
                            end
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                HOLD: begin
                    sck <= cpol_q;
                    if (tick) begin
                        ss        <= '1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx;
                        // The IDLE cycle completes the ss-high gap
                        cnt       <= DIV_WIDTH'(1);
                        state     <= (div_q == '0) ? IDLE : GAP;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                GAP: begin
                    if (tick) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
